// File: rtl/rv32_pc_gen_pkg.sv
// ============================================================================
// Module      : rv32_pc_pkg
// Description : Shared types and constants for the RV32 fetch PC generator.
//               Optional feature macro: RV32_PC_IALIGN16_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

  // Numeric order is the overwrite priority inside the redirect latch.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_MRET   = 2'd2,
    SRC_TRAP   = 2'd3
  } redirect_src_e;

  localparam int unsigned PC_INC_32 = 4;
  localparam int unsigned PC_INC_16 = 2;

`ifdef RV32_PC_IALIGN16_EN
  localparam int unsigned ALIGN_BITS = 1;
`else
  localparam int unsigned ALIGN_BITS = 2;
`endif

endpackage

`default_nettype wire

// File: rtl/rv32_pc_gen_if.sv
// ============================================================================
// Module      : rv32_pc_gen_if
// Description : Control/redirect/fetch bundle for rv32_pc_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv32_pc_gen_if #(
  parameter int PC_WIDTH    = 32,
  parameter int IADDR_WIDTH = 30
);
  logic                   stall_in;
  logic                   imem_ready_in;
  logic                   trap_in;
  logic [PC_WIDTH-1:0]    trap_address_in;
  logic                   mret_in;
  logic [PC_WIDTH-1:0]    epc_in;
  logic                   branch_taken_in;
  logic [PC_WIDTH-1:0]    branch_target_in;
  logic                   instr_is_16_in;
  logic [PC_WIDTH-1:0]    pc_out;
  logic [PC_WIDTH-1:0]    pc_plus_out;
  logic [IADDR_WIDTH-1:0] i_addr_out;
  logic                   i_req_out;
  logic                   misaligned_instr_out;
  logic [PC_WIDTH-1:0]    misaligned_addr_out;
  logic                   redirect_pending_out;

  modport master (
    output stall_in, imem_ready_in, trap_in, trap_address_in, mret_in, epc_in,
           branch_taken_in, branch_target_in, instr_is_16_in,
    input  pc_out, pc_plus_out, i_addr_out, i_req_out, misaligned_instr_out,
           misaligned_addr_out, redirect_pending_out
  );

  modport slave (
    input  stall_in, imem_ready_in, trap_in, trap_address_in, mret_in, epc_in,
           branch_taken_in, branch_target_in, instr_is_16_in,
    output pc_out, pc_plus_out, i_addr_out, i_req_out, misaligned_instr_out,
           misaligned_addr_out, redirect_pending_out
  );

endinterface

`default_nettype wire

// File: rtl/rv32_pc_gen_redirect_latch.sv
// ============================================================================
// Module      : rv32_pc_redirect_latch
// Description : Holds one redirect that arrived while fetch could not advance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_pc_redirect_latch
  import rv32_pc_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  wire logic                clk_in,
  input  wire logic                rst_n_in,
  input  wire logic                capture_in,
  input  redirect_src_e            capture_src_in,
  input  wire logic [PC_WIDTH-1:0] capture_target_in,
  input  wire logic                consume_in,
  output logic                     pending_out,
  output logic [PC_WIDTH-1:0]      pending_target_out
);

  redirect_src_e       r_src;
  logic [PC_WIDTH-1:0] r_target;

  // Equal priority overwrites so the most recent target of that class wins.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_src    <= SRC_NONE;
      r_target <= '0;
    end else if (consume_in) begin
      r_src    <= SRC_NONE;
    end else if (capture_in && (capture_src_in != SRC_NONE) &&
                 (capture_src_in >= r_src)) begin
      r_src    <= capture_src_in;
      r_target <= capture_target_in;
    end
  end

  assign pending_out        = (r_src != SRC_NONE);
  assign pending_target_out = r_target;

endmodule

`default_nettype wire

// File: rtl/rv32_pc_gen.sv
// ============================================================================
// Module      : rv32_pc_gen
// Description : Registered RV32 fetch PC generator with redirect latching and
//               misaligned-branch detection. Macro: RV32_PC_IALIGN16_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_pc_gen
  import rv32_pc_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int          PC_WIDTH     = 32,
  parameter int          IADDR_WIDTH  = 30
) (
  input  wire logic     clk_in,
  input  wire logic     rst_n_in,
  rv32_pc_gen_if.slave  pc_bus
);

  localparam logic [PC_WIDTH-1:0] c_low_mask = PC_WIDTH'((2 ** ALIGN_BITS) - 1);

  pc_state_e           r_state;
  pc_state_e           w_state_next;
  logic                w_i_req;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PC_WIDTH-1:0] w_pc_plus;
  logic [PC_WIDTH-1:0] w_inc;
  logic [PC_WIDTH-1:0] w_trap_tgt;
  logic [PC_WIDTH-1:0] w_epc_tgt;
  logic                w_branch_mis;
  logic                w_branch_ok;
  logic                w_advance;
  redirect_src_e       w_redir_src;
  logic [PC_WIDTH-1:0] w_redir_tgt;
  logic                w_pend;
  logic [PC_WIDTH-1:0] w_pend_tgt;
  logic                r_mis;
  logic [PC_WIDTH-1:0] r_mis_addr;

`ifdef RV32_PC_IALIGN16_EN
  assign w_inc = pc_bus.instr_is_16_in ? PC_WIDTH'(PC_INC_16) : PC_WIDTH'(PC_INC_32);
`else
  assign w_inc = PC_WIDTH'(PC_INC_32);
`endif

  assign w_pc_plus    = r_pc + w_inc;
  assign w_trap_tgt   = pc_bus.trap_address_in & ~c_low_mask;
  assign w_epc_tgt    = pc_bus.epc_in & ~c_low_mask;
  assign w_branch_mis = pc_bus.branch_taken_in &&
                        ((pc_bus.branch_target_in & c_low_mask) != '0);
  assign w_branch_ok  = pc_bus.branch_taken_in && !w_branch_mis;
  assign w_advance    = (r_state == RUN) && !pc_bus.stall_in && pc_bus.imem_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= BOOT;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_i_req      = 1'b0;
    case (r_state)
      BOOT: w_state_next = RUN;
      RUN: begin
        w_i_req = 1'b1;
        if (pc_bus.stall_in || !pc_bus.imem_ready_in) w_state_next = HOLD;
      end
      HOLD: begin
        w_i_req = 1'b1;
        if (!pc_bus.stall_in && pc_bus.imem_ready_in) w_state_next = RUN;
      end
      default: w_state_next = BOOT;
    endcase
  end

  // Incoming redirect this cycle, reduced to its highest-priority source.
  always_comb begin
    w_redir_src = SRC_NONE;
    w_redir_tgt = pc_bus.branch_target_in;
    if (pc_bus.trap_in) begin
      w_redir_src = SRC_TRAP;
      w_redir_tgt = w_trap_tgt;
    end else if (pc_bus.mret_in) begin
      w_redir_src = SRC_MRET;
      w_redir_tgt = w_epc_tgt;
    end else if (w_branch_ok) begin
      w_redir_src = SRC_BRANCH;
    end
  end

  always_comb begin
    w_pc_next = w_pc_plus;
    if (pc_bus.trap_in)     w_pc_next = w_trap_tgt;
    else if (pc_bus.mret_in) w_pc_next = w_epc_tgt;
    else if (w_pend)        w_pc_next = w_pend_tgt;
    else if (w_branch_ok)   w_pc_next = pc_bus.branch_target_in;
  end

  rv32_pc_redirect_latch #(
    .PC_WIDTH (PC_WIDTH)
  ) u_redirect_latch (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .capture_in         (!w_advance),
    .capture_src_in     (w_redir_src),
    .capture_target_in  (w_redir_tgt),
    .consume_in         (w_advance),
    .pending_out        (w_pend),
    .pending_target_out (w_pend_tgt)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)      r_pc <= BOOT_ADDRESS[PC_WIDTH-1:0];
    else if (w_advance) r_pc <= w_pc_next;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_mis      <= 1'b0;
      r_mis_addr <= '0;
    end else begin
      r_mis <= w_branch_mis;
      if (w_branch_mis) r_mis_addr <= pc_bus.branch_target_in;
    end
  end

  assign pc_bus.pc_out               = r_pc;
  assign pc_bus.pc_plus_out          = w_pc_plus;
  assign pc_bus.i_addr_out           = r_pc[PC_WIDTH-1:PC_WIDTH-IADDR_WIDTH];
  assign pc_bus.i_req_out            = w_i_req;
  assign pc_bus.misaligned_instr_out = r_mis;
  assign pc_bus.misaligned_addr_out  = r_mis_addr;
  assign pc_bus.redirect_pending_out = w_pend;

endmodule

`default_nettype wire

// File: tb/tb_rv32_pc_gen.sv
// ============================================================================
// Module      : tb_rv32_pc_gen
// Description : Directed self-checking bench for rv32_pc_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32_pc_gen;

`ifdef RV32_PC_IALIGN16_EN
  localparam int c_iaw = 31;
`else
  localparam int c_iaw = 30;
`endif

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  rv32_pc_gen_if #(.PC_WIDTH(32), .IADDR_WIDTH(c_iaw)) bus ();

  rv32_pc_gen #(
    .BOOT_ADDRESS (32'h8000_0000),
    .PC_WIDTH     (32),
    .IADDR_WIDTH  (c_iaw)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .pc_bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    bus.stall_in         = 1'b0;
    bus.imem_ready_in    = 1'b1;
    bus.trap_in          = 1'b0;
    bus.trap_address_in  = '0;
    bus.mret_in          = 1'b0;
    bus.epc_in           = '0;
    bus.branch_taken_in  = 1'b0;
    bus.branch_target_in = '0;
    bus.instr_is_16_in   = 1'b0;

    // Reset and boot sequence
    #2 rst_n = 1'b0;
    #1;
    check("rst_pc", bus.pc_out, 32'h8000_0000);
    check("rst_req", 32'(bus.i_req_out), 32'd0);
    check("rst_pend", 32'(bus.redirect_pending_out), 32'd0);
    check("rst_mis", 32'(bus.misaligned_instr_out), 32'd0);
    check("rst_misaddr", bus.misaligned_addr_out, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("boot_req", 32'(bus.i_req_out), 32'd0);
    tick();
    check("run_req", 32'(bus.i_req_out), 32'd1);
    check("run_pc0", bus.pc_out, 32'h8000_0000);
    tick();
    check("seq_pc1", bus.pc_out, 32'h8000_0004);
    tick();
    check("seq_pc2", bus.pc_out, 32'h8000_0008);

    // Branch arriving while imem not ready is latched
    bus.imem_ready_in    = 1'b0;
    bus.branch_taken_in  = 1'b1;
    bus.branch_target_in = 32'h100;
    tick();
    bus.branch_taken_in  = 1'b0;
    check("br_pend", 32'(bus.redirect_pending_out), 32'd1);
    check("br_hold_req", 32'(bus.i_req_out), 32'd1);
    tick();
    tick();
    check("br_frozen", bus.pc_out, 32'h8000_0008);
    bus.imem_ready_in = 1'b1;
    tick();
    check("br_resume_pc", bus.pc_out, 32'h8000_0008);
    tick();
    check("br_taken_pc", bus.pc_out, 32'h100);
    check("br_pend_clr", 32'(bus.redirect_pending_out), 32'd0);
`ifdef RV32_PC_IALIGN16_EN
    check("iaddr_100", 32'(bus.i_addr_out), 32'h80);
`else
    check("iaddr_100", 32'(bus.i_addr_out), 32'h40);
`endif

    // Trap overwrites a pending branch during the same stall
    bus.imem_ready_in    = 1'b0;
    bus.branch_taken_in  = 1'b1;
    bus.branch_target_in = 32'h200;
    tick();
    bus.branch_taken_in  = 1'b0;
    bus.trap_in          = 1'b1;
    bus.trap_address_in  = 32'h40;
    tick();
    bus.trap_in          = 1'b0;
    bus.imem_ready_in    = 1'b1;
    tick();
    tick();
    check("trap_over_pc", bus.pc_out, 32'h40);
    check("trap_pend_clr", 32'(bus.redirect_pending_out), 32'd0);
    tick();
    check("seq_44", bus.pc_out, 32'h44);

    // Trap and mret together: trap wins
    bus.trap_in         = 1'b1;
    bus.trap_address_in = 32'h40;
    bus.mret_in         = 1'b1;
    bus.epc_in          = 32'h300;
    tick();
    bus.trap_in = 1'b0;
    check("trap_mret_pc", bus.pc_out, 32'h40);

    // mret target is force-aligned
    bus.epc_in = 32'h303;
    tick();
    bus.mret_in = 1'b0;
`ifdef RV32_PC_IALIGN16_EN
    check("mret_align", bus.pc_out, 32'h302);
`else
    check("mret_align", bus.pc_out, 32'h300);
`endif

    // Branch target 0x102
    bus.branch_taken_in  = 1'b1;
    bus.branch_target_in = 32'h102;
    tick();
    bus.branch_taken_in  = 1'b0;
`ifdef RV32_PC_IALIGN16_EN
    check("mis_pc", bus.pc_out, 32'h102);
    check("mis_flag", 32'(bus.misaligned_instr_out), 32'd0);
`else
    check("mis_pc", bus.pc_out, 32'h304);
    check("mis_flag", 32'(bus.misaligned_instr_out), 32'd1);
    check("mis_addr", bus.misaligned_addr_out, 32'h102);
`endif
    tick();
    check("mis_pulse_end", 32'(bus.misaligned_instr_out), 32'd0);

    // Wrap-around at the top of the address space
    bus.branch_taken_in  = 1'b1;
    bus.branch_target_in = 32'hFFFF_FFFC;
    tick();
    bus.branch_taken_in  = 1'b0;
    check("wrap_pre", bus.pc_out, 32'hFFFF_FFFC);
`ifdef RV32_PC_IALIGN16_EN
    check("iaddr_top", 32'(bus.i_addr_out), 32'h7FFF_FFFE);
`else
    check("iaddr_top", 32'(bus.i_addr_out), 32'h3FFF_FFFF);
`endif
    tick();
    check("wrap_pc", bus.pc_out, 32'h0);
    check("wrap_noflag", 32'(bus.misaligned_instr_out), 32'd0);

    // Compressed-instruction increment
    bus.branch_taken_in  = 1'b1;
    bus.branch_target_in = 32'h10;
    tick();
    bus.branch_taken_in  = 1'b0;
    bus.instr_is_16_in   = 1'b1;
    #1;
`ifdef RV32_PC_IALIGN16_EN
    check("plus16", bus.pc_plus_out, 32'h12);
`else
    check("plus16", bus.pc_plus_out, 32'h14);
`endif
    tick();
    bus.instr_is_16_in = 1'b0;
`ifdef RV32_PC_IALIGN16_EN
    check("pc16", bus.pc_out, 32'h12);
`else
    check("pc16", bus.pc_out, 32'h14);
`endif

    // Async reset during a stall with a pending redirect
    bus.stall_in         = 1'b1;
    bus.branch_taken_in  = 1'b1;
    bus.branch_target_in = 32'h500;
    tick();
    bus.branch_taken_in  = 1'b0;
    check("stall_pend", 32'(bus.redirect_pending_out), 32'd1);
`ifdef RV32_PC_IALIGN16_EN
    check("stall_frozen", bus.pc_out, 32'h12);
`else
    check("stall_frozen", bus.pc_out, 32'h14);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", bus.pc_out, 32'h8000_0000);
    check("arst_req", 32'(bus.i_req_out), 32'd0);
    check("arst_pend", 32'(bus.redirect_pending_out), 32'd0);
    check("arst_misaddr", bus.misaligned_addr_out, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.stall_in = 1'b0;
    check("rel_req", 32'(bus.i_req_out), 32'd0);
    tick();
    check("rel_pend", 32'(bus.redirect_pending_out), 32'd0);
    tick();
    check("rel_pc", bus.pc_out, 32'h8000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
